// File: rtl/fft_peak_detect.sv
// Peak search over a serialized 8-bin FFT frame using |re|+|im| magnitudes.
// Reports one peak per complete frame and flags broken index sequences.
module fft_peak_detect #(
    parameter int             WIDTH   = 16,
    parameter bit             SKIP_DC = 1'b1,
    parameter logic [WIDTH:0] THRESH  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic [2:0]       in_index,
    output logic [2:0]       peak_index,
    output logic [WIDTH:0]   peak_mag,
    output logic             above_thresh,
    output logic             peak_valid,
    output logic             frame_err
);

    typedef enum logic {SYNC, RUN} state_t;

    state_t         state, state_d;
    logic [WIDTH:0] ext_re, ext_im, abs_re, abs_im;
    logic [WIDTH:0] s1_abs_re, s1_abs_im, mag;
    logic [2:0]     s1_index;
    logic           s1_valid;

    logic [2:0]     exp_idx, exp_idx_d;
    logic [WIDTH:0] max_mag, max_mag_d, start_mag, best_mag;
    logic [2:0]     max_idx, max_idx_d, best_idx;
    logic [2:0]     peak_index_d;
    logic [WIDTH:0] peak_mag_d;
    logic           above_d, valid_d, err_d, start;

    // sign-extend one bit so that |-2^(WIDTH-1)| is representable
    assign ext_re = {in_re[WIDTH-1], in_re};
    assign ext_im = {in_im[WIDTH-1], in_im};
    assign abs_re = ext_re[WIDTH] ? -ext_re : ext_re;
    assign abs_im = ext_im[WIDTH] ? -ext_im : ext_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_abs_re <= '0;
            s1_abs_im <= '0;
            s1_index  <= '0;
            s1_valid  <= 1'b0;
        end else begin
            s1_abs_re <= abs_re;
            s1_abs_im <= abs_im;
            s1_index  <= in_index;
            s1_valid  <= 1'b1;
        end
    end

    assign mag       = s1_abs_re + s1_abs_im;
    assign start_mag = SKIP_DC ? '0 : mag;
    assign best_mag  = (mag > max_mag) ? mag : max_mag;
    assign best_idx  = (mag > max_mag) ? s1_index : max_idx;

    always_comb begin
        state_d      = state;
        exp_idx_d    = exp_idx;
        max_mag_d    = max_mag;
        max_idx_d    = max_idx;
        peak_index_d = peak_index;
        peak_mag_d   = peak_mag;
        above_d      = above_thresh;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        start        = 1'b0;
        if (s1_valid) begin
            unique case (state)
                SYNC: start = (s1_index == 3'd0);
                RUN: begin
                    if (s1_index != exp_idx) begin
                        err_d = 1'b1;
                        start = (s1_index == 3'd0);
                        if (s1_index != 3'd0)
                            state_d = SYNC;
                    end else if (s1_index == 3'd0) begin
                        start = 1'b1;
                    end else begin
                        max_mag_d = best_mag;
                        max_idx_d = best_idx;
                        exp_idx_d = exp_idx + 3'd1;
                        if (s1_index == 3'd7) begin
                            peak_index_d = best_idx;
                            peak_mag_d   = best_mag;
                            above_d      = (best_mag >= THRESH);
                            valid_d      = 1'b1;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end
        if (start) begin
            state_d   = RUN;
            exp_idx_d = 3'd1;
            max_mag_d = start_mag;
            max_idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= SYNC;
            exp_idx      <= '0;
            max_mag      <= '0;
            max_idx      <= '0;
            peak_index   <= '0;
            peak_mag     <= '0;
            above_thresh <= 1'b0;
            peak_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_d;
            exp_idx      <= exp_idx_d;
            max_mag      <= max_mag_d;
            max_idx      <= max_idx_d;
            peak_index   <= peak_index_d;
            peak_mag     <= peak_mag_d;
            above_thresh <= above_d;
            peak_valid   <= valid_d;
            frame_err    <= err_d;
        end
    end

endmodule
